sf_fetch_ctrl: RTL and testbench

Initiator-side controller for the scale-factor generation engine. It accepts a request carrying one generation parameter and starts the engine with a one-cycle pulse. It waits for the engine's done pulse, reads the NUM_SF generated factors over the engine's synchronous read port into a local buffer, then streams them downstream over a valid/ready interface. It sits between the feature-pipeline sequencer and the generation engine, and owns the start/done handshake from the requesting side.

---
 rtl/sf_fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_sf_fetch_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sf_fetch_ctrl.sv
// rtl/sf_fetch_ctrl.sv - start/done initiator that fetches and streams generated scale factors
module sf_fetch_ctrl #(
    parameter int DATA_W  = 16,
    parameter int NUM_SF  = 8,
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_param,
    output logic              gen_start,
    output logic [DATA_W-1:0] gen_param,
    input  logic              gen_done,
    output logic [ADDR_W-1:0] gen_rd_addr,
    input  logic [DATA_W-1:0] gen_rd_data,
    output logic              sf_valid,
    input  logic              sf_ready,
    output logic [DATA_W-1:0] sf_data,
    output logic [ADDR_W-1:0] sf_idx,
    output logic              sf_last,
    output logic              err_timeout
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_Idle,
        S_Start,
        S_Wait,
        S_Read,
        S_Stream
    } STATES_t;

    STATES_t           state;
    STATES_t           state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W:0]   rd_cnt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] cap_idx;
    logic [DATA_W-1:0] param_q;
    logic              err_q;
    logic [DATA_W-1:0] buffer [NUM_SF];

    logic req_fire;
    logic sf_fire;
    logic is_last;
    logic rd_done;
    logic wait_expired;

    assign req_fire     = (state == S_Idle) && req_valid;
    assign sf_fire      = (state == S_Stream) && sf_ready;
    assign is_last      = (idx == ADDR_W'(NUM_SF - 1));
    // rd_cnt runs one past the last address so the final word can be captured
    assign rd_done      = (rd_cnt == (ADDR_W + 1)'(NUM_SF));
    assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign cap_idx      = ADDR_W'(rd_cnt - (ADDR_W + 1)'(1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_Idle;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; done takes priority over the timeout boundary
    always_comb begin
        state_nxt = state;
        case (state)
            S_Idle:   if (req_valid) state_nxt = S_Start;
            S_Start:  state_nxt = S_Wait;
            S_Wait: begin
                if (gen_done) begin
                    state_nxt = S_Read;
                end else if (wait_expired) begin
                    state_nxt = S_Idle;
                end
            end
            S_Read:   if (rd_done) state_nxt = S_Stream;
            S_Stream: if (sf_ready && is_last) state_nxt = S_Idle;
            default:  state_nxt = S_Idle;
        endcase
    end

    // Control registers: parameter latch, sticky timeout, wait/read counters, stream index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            param_q  <= '0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
            rd_cnt   <= '0;
            idx      <= '0;
        end else begin
            if (req_fire) begin
                param_q <= req_param;
                err_q   <= 1'b0;
            end
            if (state == S_Wait && !gen_done && wait_expired) begin
                err_q <= 1'b1;
            end
            if (state == S_Start) begin
                wait_cnt <= '0;
            end else if (state == S_Wait) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (state == S_Read) begin
                rd_cnt <= rd_cnt + (ADDR_W + 1)'(1);
            end else begin
                rd_cnt <= '0;
            end
            if (sf_fire) begin
                idx <= is_last ? '0 : idx + ADDR_W'(1);
            end
        end
    end

    // Capture engine data one cycle after its address was presented
    always_ff @(posedge clk) begin
        if (state == S_Read && rd_cnt != '0) begin
            buffer[cap_idx] <= gen_rd_data;
        end
    end

    assign req_ready   = (state == S_Idle);
    assign gen_start   = (state == S_Start);
    assign gen_param   = param_q;
    assign gen_rd_addr = (state == S_Read && !rd_done) ? rd_cnt[ADDR_W-1:0] : '0;
    assign sf_valid    = (state == S_Stream);
    assign sf_idx      = idx;
    assign sf_last     = sf_valid && is_last;
    assign sf_data     = sf_valid ? buffer[idx] : '0;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_sf_fetch_ctrl.sv
// tb/tb_sf_fetch_ctrl.sv - directed self-checking bench for sf_fetch_ctrl
module tb_sf_fetch_ctrl;

    localparam int DATA_W  = 16;
    localparam int NUM_SF  = 8;
    localparam int ADDR_W  = 3;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [DATA_W-1:0] req_param = '0;
    logic              gen_start;
    logic [DATA_W-1:0] gen_param;
    logic              gen_done = 1'b0;
    logic [ADDR_W-1:0] gen_rd_addr;
    logic [DATA_W-1:0] gen_rd_data = '0;
    logic              sf_valid;
    logic              sf_ready = 1'b0;
    logic [DATA_W-1:0] sf_data;
    logic [ADDR_W-1:0] sf_idx;
    logic              sf_last;
    logic              err_timeout;

    int                n_vec  = 0;
    int                n_miss = 0;
    logic [DATA_W-1:0] rd_base = 16'h1000;
    logic [ADDR_W-1:0] last_addr = '0;

    sf_fetch_ctrl #(
        .DATA_W (DATA_W),
        .NUM_SF (NUM_SF),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_param  (req_param),
        .gen_start  (gen_start),
        .gen_param  (gen_param),
        .gen_done   (gen_done),
        .gen_rd_addr(gen_rd_addr),
        .gen_rd_data(gen_rd_data),
        .sf_valid   (sf_valid),
        .sf_ready   (sf_ready),
        .sf_data    (sf_data),
        .sf_idx     (sf_idx),
        .sf_last    (sf_last),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle; the engine model answers the previous cycle's address
    task automatic tick();
        @(posedge clk);
        #1;
        gen_rd_data = rd_base + DATA_W'(last_addr);
        last_addr   = gen_rd_addr;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_gen_start"}, gen_start, 0);
        chk({tag, "_gen_param"}, gen_param, 0);
        chk({tag, "_rd_addr"}, gen_rd_addr, 0);
        chk({tag, "_sf_valid"}, sf_valid, 0);
        chk({tag, "_sf_idx"}, sf_idx, 0);
        chk({tag, "_sf_data"}, sf_data, 0);
        chk({tag, "_sf_last"}, sf_last, 0);
        chk({tag, "_err"}, err_timeout, 0);
    endtask

    // One full transaction. dly<0: engine never answers. bp=1: ready pattern 1,0,0.
    // abort_n>0: reset after that many handshakes. spur: stray done and held request in stream.
    task automatic do_gen(input logic [DATA_W-1:0] p, input int dly, input int bp,
                          input int abort_n, input bit spur);
        int m;
        int hs;
        int exp_idx;
        req_valid = 1'b1;
        req_param = p;
        chk("req_ready_idle", req_ready, 1);
        tick();
        req_valid = 1'b0;
        req_param = '0;
        chk("gen_start", gen_start, 1);
        chk("gen_param", gen_param, 32'(p));
        chk("err_cleared", err_timeout, 0);

        if (dly < 0) begin
            for (int k = 1; k <= TIMEOUT + 1; k++) begin
                tick();
                if (k <= TIMEOUT) begin
                    chk("to_no_valid", sf_valid, 0);
                    chk("to_no_start", gen_start, 0);
                end
                if (k == TIMEOUT) begin
                    chk("to_err_early", err_timeout, 0);
                    chk("to_ready_early", req_ready, 0);
                end
                if (k == TIMEOUT + 1) begin
                    chk("to_err", err_timeout, 1);
                    chk("to_ready", req_ready, 1);
                    chk("to_valid", sf_valid, 0);
                end
            end
            return;
        end

        for (int k = 1; k <= dly; k++) begin
            tick();
            chk("wait_no_start", gen_start, 0);
            if (k == dly) gen_done = 1'b1;
        end

        m = 0;
        while (!sf_valid && m < 40) begin
            tick();
            gen_done = 1'b0;
            m++;
            if (m == 1) chk("rd_addr_first", gen_rd_addr, 0);
            if (m == NUM_SF) chk("rd_addr_last", gen_rd_addr, NUM_SF - 1);
        end
        chk("first_valid_lat", m, NUM_SF + 2);

        hs = 0;
        exp_idx = 0;
        for (int j = 0; j < 100 && exp_idx < NUM_SF; j++) begin
            sf_ready = (bp == 0) ? 1'b1 : ((j % 3) == 0);
            if (spur) begin
                req_valid = 1'b1;
                req_param = 16'h0BAD;
                gen_done  = (j == 0);
            end
            chk("sf_valid", sf_valid, 1);
            chk("sf_idx", sf_idx, exp_idx);
            chk("sf_data", sf_data, 32'(rd_base) + exp_idx);
            chk("sf_last", sf_last, exp_idx == NUM_SF - 1);
            if (spur) chk("no_accept_stream", req_ready, 0);
            if (sf_ready) begin
                hs++;
                exp_idx++;
            end
            tick();
            gen_done = 1'b0;
            sf_ready = 1'b0;
            if (hs == abort_n) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                chk_reset_outputs("mid_rst");
                return;
            end
        end
        chk("stream_count", exp_idx, NUM_SF);
        chk("end_ready", req_ready, 1);
        chk("end_valid", sf_valid, 0);
        chk("end_start", gen_start, 0);

        if (spur) begin
            tick();
            req_valid = 1'b0;
            req_param = '0;
            chk("held_req_start", gen_start, 1);
            chk("held_req_param", gen_param, 16'h0BAD);
            m = 0;
            while (!req_ready && m < 40) begin
                tick();
                m++;
            end
            chk("held_req_timeout", err_timeout, 1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk_reset_outputs("reset");

        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        chk("idle_done_ready", req_ready, 1);
        chk("idle_done_start", gen_start, 0);
        chk("idle_done_addr", gen_rd_addr, 0);
        tick();
        chk("idle_done_valid", sf_valid, 0);

        rd_base = 16'h1000;
        do_gen(16'h0123, 5, 0, -1, 1'b0);
        do_gen(16'h0456, 5, 1, -1, 1'b0);
        do_gen(16'h0789, -1, 0, -1, 1'b0);
        do_gen(16'h0ABC, TIMEOUT, 0, -1, 1'b0);
        chk("boundary_err", err_timeout, 0);

        do_gen(16'h0DEF, 5, 0, 3, 1'b0);
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        chk("post_rst_done_ready", req_ready, 1);
        chk("post_rst_done_start", gen_start, 0);
        rd_base = 16'h2000;
        do_gen(16'h0111, 5, 0, -1, 1'b0);

        rd_base = 16'h3000;
        do_gen(16'h0222, 5, 1, -1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
